// File: rtl/sr_lsu_if.sv
// Memory-side bus of the single-request load/store unit.
interface sr_lsu_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;

  modport master (output req, we, addr, be, wdata, input gnt, rvalid, rdata);
  modport slave  (input req, we, addr, be, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/sr_lsu.sv
// Single-request load/store unit: one core access at a time over a req/gnt/rvalid bus.
// Optional macro SR_LSU_MISALIGN_TRAP_EN traps misaligned half/word accesses instead of aligning them.
module sr_lsu #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        stall,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  sr_lsu_if.master    mem
);

  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, WAIT = 2'd2, RESP = 2'd3} state_t;

  state_t      state_r, state_s;
  logic [15:0] cnt_r;
  logic [31:0] addr_r, wdata_r, rdata_r;
  logic [3:0]  be_r;
  logic        we_r, err_r, uns_r;
  logic [1:0]  size_r, off_r;
  logic        legal_s, timeout_s;
  logic [1:0]  off_s;
  logic [3:0]  be_s;
  logic [31:0] wdata_s, lane_s, load_s;

  // Decode size/offset, byte enables and replicated store data of the incoming request
  always_comb begin
    off_s   = 2'b00;
    be_s    = 4'b0000;
    wdata_s = 32'h0000_0000;
    case (req_size)
      2'd0: begin
        off_s   = req_addr[1:0];
        be_s    = 4'b0001 << req_addr[1:0];
        wdata_s = {4{req_wdata[7:0]}};
      end
      2'd1: begin
        off_s   = {req_addr[1], 1'b0};
        be_s    = req_addr[1] ? 4'b1100 : 4'b0011;
        wdata_s = {2{req_wdata[15:0]}};
      end
      2'd2: begin
        off_s   = 2'b00;
        be_s    = 4'b1111;
        wdata_s = req_wdata;
      end
      default: begin
        off_s   = 2'b00;
        be_s    = 4'b0000;
        wdata_s = 32'h0000_0000;
      end
    endcase
`ifdef SR_LSU_MISALIGN_TRAP_EN
    legal_s = (req_size != 2'd3) &&
              !((req_size == 2'd1 && req_addr[0]) ||
                (req_size == 2'd2 && req_addr[1:0] != 2'b00));
`else
    legal_s = (req_size != 2'd3);
`endif
  end

  // Select the addressed lane of the returned word and extend it
  always_comb begin
    lane_s = mem.rdata >> {off_r, 3'b000};
    load_s = mem.rdata;
    case (size_r)
      2'd0:    load_s = uns_r ? {24'h00_0000, lane_s[7:0]} : {{24{lane_s[7]}}, lane_s[7:0]};
      2'd1:    load_s = uns_r ? {16'h0000, lane_s[15:0]} : {{16{lane_s[15]}}, lane_s[15:0]};
      default: load_s = mem.rdata;
    endcase
  end

  // Next-state logic; gnt/rvalid win over a timeout in the same cycle
  always_comb begin
    state_s   = state_r;
    timeout_s = (cnt_r == TO_LAST);
    case (state_r)
      IDLE: begin
        if (req_valid) state_s = legal_s ? REQ : RESP;
        else           state_s = IDLE;
      end
      REQ: begin
        if (mem.gnt)        state_s = we_r ? RESP : WAIT;
        else if (timeout_s) state_s = RESP;
        else                state_s = REQ;
      end
      WAIT: begin
        if (mem.rvalid)     state_s = RESP;
        else if (timeout_s) state_s = RESP;
        else                state_s = WAIT;
      end
      RESP:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_r <= IDLE;
    else     state_r <= state_s;
  end

  // Wait counter, request latches and response registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r   <= 16'h0000;
      addr_r  <= 32'h0000_0000;
      wdata_r <= 32'h0000_0000;
      rdata_r <= 32'h0000_0000;
      be_r    <= 4'b0000;
      we_r    <= 1'b0;
      err_r   <= 1'b0;
      uns_r   <= 1'b0;
      size_r  <= 2'd0;
      off_r   <= 2'd0;
    end else begin
      if (state_s != state_r)                    cnt_r <= 16'h0000;
      else if (state_r == REQ || state_r == WAIT) cnt_r <= cnt_r + 16'h0001;
      else                                       cnt_r <= 16'h0000;
      case (state_r)
        IDLE: begin
          if (req_valid) begin
            rdata_r <= 32'h0000_0000;
            err_r   <= !legal_s;
            if (legal_s) begin
              addr_r  <= {req_addr[31:2], 2'b00};
              be_r    <= be_s;
              wdata_r <= wdata_s;
              we_r    <= req_we;
              size_r  <= req_size;
              uns_r   <= req_unsigned;
              off_r   <= off_s;
            end
          end
        end
        REQ: begin
          if (mem.gnt)        err_r <= 1'b0;
          else if (timeout_s) err_r <= 1'b1;
        end
        WAIT: begin
          if (mem.rvalid) begin
            rdata_r <= load_s;
            err_r   <= 1'b0;
          end else if (timeout_s) begin
            err_r   <= 1'b1;
          end
        end
        RESP: begin
          rdata_r <= 32'h0000_0000;
          err_r   <= 1'b0;
        end
        default: begin
          rdata_r <= 32'h0000_0000;
          err_r   <= 1'b0;
        end
      endcase
    end
  end

  assign stall     = req_valid && (state_r != RESP);
  assign rsp_valid = (state_r == RESP);
  assign rsp_rdata = rdata_r;
  assign rsp_err   = err_r;
  assign mem.req   = (state_r == REQ);
  assign mem.we    = we_r;
  assign mem.addr  = addr_r;
  assign mem.be    = be_r;
  assign mem.wdata = wdata_r;

endmodule

// File: doc/sr_lsu.md
SR_LSU -- requirements
Module: sr_lsu

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255: max cycles waiting for mem_gnt or mem_rvalid before bus error; legal 1..65535.
REQ-002 SHALL have port clk  input  1  core clock; all state on rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port req_valid  input  1  core issues load/store this cycle.
REQ-005 SHALL have port req_we  input  1  1=store, 0=load.
REQ-006 SHALL have port req_size  input  2  0=byte, 1=half, 2=word; 3 is illegal.
REQ-007 SHALL have port req_unsigned  input  1  zero-extend load result (LBU/LHU).
REQ-008 SHALL have port req_addr  input  32  byte address (ALU result).
REQ-009 SHALL have port req_wdata  input  32  store data, value in low bits.
REQ-010 SHALL have port stall  output  1  core must hold its request and PC.
REQ-011 SHALL have port rsp_valid  output  1  one-cycle pulse: access finished.
REQ-012 SHALL have port rsp_rdata  output  32  extended load data, valid with rsp_valid.
REQ-013 SHALL have port rsp_err  output  1  with rsp_valid: misalign, illegal size or timeout.
REQ-014 SHALL have ports mem_req/mem_we (out 1), mem_addr (out 32, bits[1:0]=0), mem_be (out 4), mem_wdata (out 32), mem_gnt (in 1), mem_rvalid (in 1), mem_rdata (in 32).

Function
REQ-015 SHALL implement FSM IDLE, REQ, WAIT, RESP.
- IDLE -> REQ on req_valid with legal access; IDLE -> RESP with rsp_err=1 otherwise, no bus activity.
REQ-016 SHALL latch address, size, unsigned, we and lane-shifted wdata/be when leaving IDLE; inputs ignored until the FSM returns to IDLE.
REQ-017 SHALL hold mem_req=1 with stable mem_addr/mem_we/mem_be/mem_wdata in REQ until mem_gnt=1.
REQ-018 SHALL, on grant, go to RESP for stores and WAIT for loads; in WAIT, mem_rvalid=1 captures mem_rdata and goes to RESP.
REQ-019 SHALL assert rsp_valid for exactly one cycle in RESP, then return to IDLE; no back-to-back acceptance in that RESP cycle.
REQ-020 SHALL drive stall=1 combinationally whenever req_valid=1 and state != RESP; stall=0 in RESP.
- Minimum latency: store 2 cycles (req->RESP with gnt in first REQ cycle), load 3 cycles (rvalid same cycle as entering WAIT not allowed; earliest the next).
REQ-021 SHALL compute mem_be: byte = 1<<addr[1:0]; half = 0011 or 1100 by addr[1]; word = 1111; mem_wdata replicates byte/half across lanes.
REQ-022 SHALL extract load lane by addr[1:0] and sign-extend from bit 7/15 unless req_unsigned; word returned unchanged.
REQ-023 SHALL count cycles in REQ and WAIT with a 16-bit counter cleared on each state entry; reaching TIMEOUT forces RESP with rsp_err=1, mem_req dropped.
REQ-024 SHALL ignore mem_rvalid outside WAIT and mem_gnt outside REQ.
REQ-025 SHALL set rsp_rdata=0 for stores and errored accesses.

Reset
REQ-026 SHALL, on rst=1 at any time (including mid-transaction), return to IDLE asynchronously, abandoning any bus transfer.
REQ-027 SHALL reset outputs: stall follows REQ-020 from IDLE, rsp_valid=0, rsp_rdata=0, rsp_err=0, mem_req=0, mem_we=0, mem_be=0, mem_addr=0, mem_wdata=0, counter=0.

Configuration
REQ-028 SHALL honour macro SR_LSU_MISALIGN_TRAP_EN.
- Defined: half with addr[0]=1 or word with addr[1:0]!=0 completes via RESP with rsp_err=1, no bus request.
- Undefined: low address bits are silently cleared to natural alignment (half: addr[0]=0, word: addr[1:0]=0), access proceeds normally, rsp_err only for illegal size or timeout.

Verification
REQ-029 SHALL cover: store word 0xDEADBEEF to 0x100, gnt immediate -> mem_be=1111, mem_addr=0x100, rsp_valid 2 cycles after req, rsp_err=0.
REQ-030 SHALL cover: load byte signed from 0x103, mem_rdata=0x80FF_FF7F -> rsp_rdata=0xFFFFFF80; same with req_unsigned -> 0x00000080.
REQ-031 SHALL cover: store half 0x1234 to 0x202 -> mem_be=1100, mem_wdata=0x12341234, mem_addr=0x200.
REQ-032 SHALL cover: load word 0x4, gnt withheld TIMEOUT=4 cycles -> mem_req drops, rsp_valid=1, rsp_err=1.
REQ-033 SHALL cover: load word 0x6 -> with SR_LSU_MISALIGN_TRAP_EN rsp_err=1, no mem_req; without, mem_addr=0x4, normal completion.
REQ-034 SHALL cover: rst asserted in WAIT -> mem_req=0, rsp_valid=0 immediately; next request served normally.
